shift_reg_univ: RTL and testbench
=================================

SHIFT_REG_UNIV -- requirements
Module: shift_reg_univ

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the register width; legal range 2..64.
REQ-002 Parameter CNT_W, default $clog2(WIDTH)+1, SHALL set the width of nbits; it is derived and not overridden.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 mode  input  3  SHALL select the operation: 000 hold, 001 shift right, 010 shift left, 011 parallel load, 100 rotate right, 101 rotate left, 110/111 hold.
REQ-006 s_in_r  input  1  SHALL be the serial input entering bit WIDTH-1 on shift right.
REQ-007 s_in_l  input  1  SHALL be the serial input entering bit 0 on shift left.
REQ-008 p_in  input  WIDTH  SHALL be the parallel load data.
REQ-009 start  input  1  SHALL request a burst of nbits shift/rotate operations.
REQ-010 nbits  input  CNT_W  SHALL give the burst length.
REQ-011 Q  output  WIDTH  SHALL be the register contents, driven directly from a flop.
REQ-012 s_out  output  1  SHALL be the bit most recently shifted or rotated out, registered.
REQ-013 busy  output  1  SHALL be high while a burst is executing, registered.
REQ-014 done  output  1  SHALL be a one-cycle pulse marking burst completion, registered.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DONE.
REQ-016 IDLE without an accepted start: the mode operation SHALL be applied at every edge.
  - shift right: Q <= {s_in_r, Q[W-1:1]}, s_out <= Q[0]
  - shift left: Q <= {Q[W-2:0], s_in_l}, s_out <= Q[W-1]
  - rotate right: Q <= {Q[0], Q[W-1:1]}, s_out <= Q[0]
  - rotate left: Q <= {Q[W-2:0], Q[W-1]}, s_out <= Q[W-1]
  - load: Q <= p_in, s_out unchanged
  - hold: Q and s_out unchanged
REQ-017 Start SHALL be accepted only in IDLE, with start=1, nbits!=0, and mode in {001,010,100,101}; any other start SHALL be ignored and REQ-016 applied.
REQ-018 Acceptance at edge k SHALL latch the mode and the count (min(nbits, WIDTH)), leave Q and s_out unchanged, and enter RUN.
REQ-019 RUN SHALL perform exactly one latched operation per edge at edges k+1..k+n, per REQ-016 rules, sampling s_in_r/s_in_l live; after edge k+n the FSM SHALL enter DONE.
REQ-020 busy SHALL be 1 exactly while in RUN (n cycles); done SHALL be 1 exactly while in DONE (one cycle); both never high together.
REQ-021 DONE SHALL hold Q and s_out, then return to IDLE at the next edge; start is not accepted in DONE.
REQ-022 In RUN and DONE, mode, p_in, start and nbits SHALL be ignored; load cannot interrupt a burst.
REQ-023 nbits > WIDTH SHALL clamp to WIDTH; nbits=0 SHALL never start a burst.
REQ-024 A burst SHALL be accepted in the cycle immediately after DONE (back-to-back bursts, with a one-cycle IDLE gap).

Reset
REQ-025 rst_n=0 at an edge SHALL force Q=0, s_out=0, busy=0, done=0, state=IDLE, and latched count/mode=0, regardless of state.
REQ-026 Reset SHALL take priority over start and mode; a burst aborted by reset SHALL produce no done pulse.
REQ-027 Power-up initial values SHALL equal the reset values.

Verification
REQ-028 Reset check: rst_n=0 for one edge -> Q=0x00, s_out=0, busy=0, done=0.
REQ-029 Load/shift check (WIDTH=8): mode=011, p_in=0xA5 -> Q=0xA5; then mode=001, s_in_r=1 -> Q=0xD2, s_out=1.
REQ-030 Burst check: Q=0x81, start with mode=101, nbits=3 -> busy high 3 cycles, Q=0x03, 0x06, 0x0C, then done high 1 cycle with Q=0x0C and s_out=0.
REQ-031 Clamp check: Q=0x5A, start with mode=100, nbits=12 -> exactly 8 busy cycles, final Q=0x5A, one done pulse.
REQ-032 Abort check: rst_n=0 during the 2nd RUN cycle -> next edge Q=0x00, busy=0, and done never asserts.
REQ-033 Ignored-start check: start=1, nbits=0, mode=011, p_in=0x3C -> Q=0x3C, busy stays 0; and start=1 during RUN -> no effect on the count.

Source files
------------

// File: rtl/shift_reg_univ.sv
//------------------------------------------------------------------------------
// ShiftRegUniv -- universal shift register with a counted burst engine
//
// Purpose:
//   A WIDTH-bit register that can hold, shift right/left, rotate right/left or
//   parallel load every clock. A start request in IDLE launches a burst of
//   nbits shift/rotate operations (clamped to WIDTH). busy is high while the
//   burst runs and done pulses for one cycle when it finishes.
//
// Ports:
//   clk     in   1      single clock, rising edge
//   rst_n   in   1      synchronous active-low reset
//   mode    in   3      000 hold, 001 shr, 010 shl, 011 load, 100 ror,
//                       101 rol, 110/111 hold
//   s_in_r  in   1      serial bit entering the MSB on shift right
//   s_in_l  in   1      serial bit entering the LSB on shift left
//   p_in    in   WIDTH  parallel load data
//   start   in   1      burst request
//   nbits   in   CNT_W  burst length
//   Q       out  WIDTH  register contents (flop output)
//   s_out   out  1      last bit shifted or rotated out (flop output)
//   busy    out  1      burst in progress (flop output)
//   done    out  1      one-cycle burst completion pulse (flop output)
//------------------------------------------------------------------------------
module shift_reg_univ #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       mode,
  input  logic             s_in_r,
  input  logic             s_in_l,
  input  logic [WIDTH-1:0] p_in,
  input  logic             start,
  input  logic [CNT_W-1:0] nbits,
  output logic [WIDTH-1:0] Q,
  output logic             s_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;

  // Declaration initialisers give power-up values identical to reset.
  state_t           r_state = ST_IDLE;
  logic [WIDTH-1:0] r_q     = '0;
  logic             r_sout  = 1'b0;
  logic             r_busy  = 1'b0;
  logic             r_done  = 1'b0;
  logic [CNT_W-1:0] r_cnt   = '0;
  logic [2:0]       r_mode  = '0;

  state_t           w_nextState;
  logic             w_isBurstMode;
  logic             w_accept;
  logic [CNT_W-1:0] w_cntClamped;
  logic [2:0]       w_opMode;
  logic [WIDTH-1:0] w_opQ;
  logic             w_opSout;

  assign Q     = r_q;
  assign s_out = r_sout;
  assign busy  = r_busy;
  assign done  = r_done;

  // A burst only makes sense for the four shift/rotate modes; load and hold
  // requests with start asserted fall back to the ordinary per-edge behaviour.
  always_comb begin
    w_isBurstMode = (mode == MODE_SHR) || (mode == MODE_SHL) ||
                    (mode == MODE_ROR) || (mode == MODE_ROL);
    w_accept      = (r_state == ST_IDLE) && start && (nbits != '0) && w_isBurstMode;
    w_cntClamped  = (nbits > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : nbits;
  end

  // The operation applied at this edge: the latched burst mode while running,
  // otherwise the live mode input. Anything unrecognised holds.
  always_comb begin
    w_opMode = (r_state == ST_RUN) ? r_mode : mode;
    w_opQ    = r_q;
    w_opSout = r_sout;
    case (w_opMode)
      MODE_SHR: begin
        w_opQ    = {s_in_r, r_q[WIDTH-1:1]};
        w_opSout = r_q[0];
      end
      MODE_SHL: begin
        w_opQ    = {r_q[WIDTH-2:0], s_in_l};
        w_opSout = r_q[WIDTH-1];
      end
      MODE_LOAD: begin
        w_opQ    = p_in;
      end
      MODE_ROR: begin
        w_opQ    = {r_q[0], r_q[WIDTH-1:1]};
        w_opSout = r_q[0];
      end
      MODE_ROL: begin
        w_opQ    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_opSout = r_q[WIDTH-1];
      end
      default: begin
      end
    endcase
  end

  // Burst sequencing: the last RUN edge is the one where one op remains.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_nextState = ST_RUN;
      ST_RUN:  if (r_cnt == CNT_W'(1)) w_nextState = ST_DONE;
      ST_DONE: w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // State, datapath and status flops. busy/done are registered copies of the
  // next state so they line up exactly with RUN and DONE. The accepting edge
  // only latches mode and count; Q and s_out move from the next edge on.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_sout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_mode  <= '0;
    end else begin
      r_state <= w_nextState;
      r_busy  <= (w_nextState == ST_RUN);
      r_done  <= (w_nextState == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_mode <= mode;
            r_cnt  <= w_cntClamped;
          end else begin
            r_q    <= w_opQ;
            r_sout <= w_opSout;
          end
        end
        ST_RUN: begin
          r_q    <= w_opQ;
          r_sout <= w_opSout;
          r_cnt  <= r_cnt - CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_reg_univ.sv
//------------------------------------------------------------------------------
// TbShiftRegUniv -- self-checking bench for shift_reg_univ (WIDTH = 8)
//
// Purpose:
//   Drives a table of hand-derived vectors, a few multi-cycle sequences
//   (reset abort, back-to-back bursts) and a randomized run compared against a
//   behavioural model of the register.
//
// Ports: none (top-level bench).
//------------------------------------------------------------------------------
module tb_shift_reg_univ;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [2:0]       mode;
  logic             s_in_r;
  logic             s_in_l;
  logic [WIDTH-1:0] p_in;
  logic             start;
  logic [CNT_W-1:0] nbits;
  logic [WIDTH-1:0] Q;
  logic             s_out;
  logic             busy;
  logic             done;

  int nAssert = 0;
  int nFail   = 0;

  // Behavioural model: register value as a plain integer, the number of burst
  // operations still to perform, and a flag for the completion cycle.
  int mQ    = 0;
  bit mS    = 1'b0;
  int mRem  = 0;
  bit mDone = 1'b0;
  int mMode = 0;

  typedef struct {
    bit rstN;
    int mode;
    bit sinR;
    bit sinL;
    int pIn;
    bit start;
    int nbits;
    int expQ;
    bit expS;
    bit expB;
    bit expD;
  } vec_t;

  vec_t vecs[$];

  shift_reg_univ #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .mode   (mode),
    .s_in_r (s_in_r),
    .s_in_l (s_in_l),
    .p_in   (p_in),
    .start  (start),
    .nbits  (nbits),
    .Q      (Q),
    .s_out  (s_out),
    .busy   (busy),
    .done   (done)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One shift/rotate/load step on the model, using arithmetic on the value.
  function automatic void modelOp(input int m);
    case (m)
      1: begin mS = (mQ % 2) == 1; mQ = mQ / 2 + (s_in_r ? 128 : 0); end
      2: begin mS = mQ >= 128;     mQ = (mQ * 2) % 256 + (s_in_l ? 1 : 0); end
      3: begin mQ = int'(p_in); end
      4: begin mS = (mQ % 2) == 1; mQ = mQ / 2 + (mS ? 128 : 0); end
      5: begin mS = mQ >= 128;     mQ = (mQ * 2) % 256 + (mS ? 1 : 0); end
      default: begin end
    endcase
  endfunction

  // What one rising edge does to the model, given the inputs presented.
  function automatic void modelEdge();
    int m;
    int n;
    m = int'(mode);
    n = int'(nbits);
    if (!rst_n) begin
      mQ = 0; mS = 1'b0; mRem = 0; mDone = 1'b0; mMode = 0;
    end else if (mRem > 0) begin
      modelOp(mMode);
      mRem = mRem - 1;
      if (mRem == 0) mDone = 1'b1;
    end else if (mDone) begin
      mDone = 1'b0;
    end else if (start && n != 0 && (m == 1 || m == 2 || m == 4 || m == 5)) begin
      mMode = m;
      mRem  = (n > WIDTH) ? WIDTH : n;
    end else begin
      modelOp(m);
    end
  endfunction

  // Present inputs, advance one edge, update the model, then settle past it.
  task automatic applyStimulus(input bit r, input int m, input bit sr, input bit sl,
                               input int p, input bit st, input int nb);
    rst_n  = r;
    mode   = 3'(m);
    s_in_r = sr;
    s_in_l = sl;
    p_in   = 8'(p);
    start  = st;
    nbits  = 4'(nb);
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic checkOutput(input string name, input int eQ, input bit eS,
                             input bit eB, input bit eD);
    nAssert++;
    if (Q !== 8'(eQ)) begin
      nFail++;
      $display("[TB] FAIL %s Q: got %h expected %h", name, Q, 8'(eQ));
    end
    nAssert++;
    if (s_out !== eS) begin
      nFail++;
      $display("[TB] FAIL %s s_out: got %b expected %b", name, s_out, eS);
    end
    nAssert++;
    if (busy !== eB) begin
      nFail++;
      $display("[TB] FAIL %s busy: got %b expected %b", name, busy, eB);
    end
    nAssert++;
    if (done !== eD) begin
      nFail++;
      $display("[TB] FAIL %s done: got %b expected %b", name, done, eD);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, mQ, mS, mRem > 0, mDone);
  endtask

  function automatic void addVec(input bit r, input int m, input bit sr, input bit sl,
                                 input int p, input bit st, input int nb,
                                 input int eQ, input bit eS, input bit eB, input bit eD);
    vec_t v;
    v.rstN = r;  v.mode = m;   v.sinR = sr;  v.sinL = sl;  v.pIn = p;
    v.start = st; v.nbits = nb; v.expQ = eQ; v.expS = eS; v.expB = eB; v.expD = eD;
    vecs.push_back(v);
  endfunction

  initial begin
    rst_n = 1'b0; mode = 3'd0; s_in_r = 1'b0; s_in_l = 1'b0;
    p_in = '0; start = 1'b0; nbits = '0;

    // Hand-derived vectors: reset, load/shift, 3-step rotate-left burst,
    // clamped rotate-right burst, starts that must be ignored.
    addVec(0, 0, 0, 0, 'h00, 0,  0, 'h00, 0, 0, 0);
    addVec(1, 3, 0, 0, 'hA5, 0,  0, 'hA5, 0, 0, 0);
    addVec(1, 1, 1, 0, 'h00, 0,  0, 'hD2, 1, 0, 0);
    addVec(1, 0, 0, 0, 'h00, 0,  0, 'hD2, 1, 0, 0);
    addVec(1, 3, 0, 0, 'h81, 0,  0, 'h81, 1, 0, 0);
    addVec(1, 5, 0, 0, 'h00, 1,  3, 'h81, 1, 1, 0);
    addVec(1, 0, 0, 0, 'h00, 0,  0, 'h03, 1, 1, 0);
    addVec(1, 3, 0, 0, 'hFF, 0,  0, 'h06, 0, 1, 0);
    addVec(1, 0, 0, 0, 'h00, 0,  0, 'h0C, 0, 0, 1);
    addVec(1, 1, 1, 0, 'h00, 1,  2, 'h0C, 0, 0, 0);
    addVec(1, 3, 0, 0, 'h5A, 0,  0, 'h5A, 0, 0, 0);
    addVec(1, 4, 0, 0, 'h00, 1, 12, 'h5A, 0, 1, 0);
    addVec(1, 1, 1, 1, 'hFF, 1,  1, 'h2D, 0, 1, 0);
    addVec(1, 0, 0, 0, 'h00, 0,  0, 'h96, 1, 1, 0);
    addVec(1, 0, 0, 0, 'h00, 0,  0, 'h4B, 0, 1, 0);
    addVec(1, 0, 0, 0, 'h00, 0,  0, 'hA5, 1, 1, 0);
    addVec(1, 0, 0, 0, 'h00, 0,  0, 'hD2, 1, 1, 0);
    addVec(1, 0, 0, 0, 'h00, 0,  0, 'h69, 0, 1, 0);
    addVec(1, 0, 0, 0, 'h00, 0,  0, 'hB4, 1, 1, 0);
    addVec(1, 0, 0, 0, 'h00, 0,  0, 'h5A, 0, 0, 1);
    addVec(1, 0, 0, 0, 'h00, 0,  0, 'h5A, 0, 0, 0);
    addVec(1, 3, 0, 0, 'h3C, 1,  0, 'h3C, 0, 0, 0);
    addVec(1, 3, 0, 0, 'h77, 1,  5, 'h77, 0, 0, 0);

    $display("[TB] Table phase: %0d vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].mode, vecs[i].sinR, vecs[i].sinL,
                    vecs[i].pIn, vecs[i].start, vecs[i].nbits);
      checkOutput($sformatf("vec%0d", i), vecs[i].expQ, vecs[i].expS,
                  vecs[i].expB, vecs[i].expD);
    end

    // Abort: reset during the second RUN cycle kills the burst silently.
    $display("[TB] Abort sequence");
    applyStimulus(1, 3, 0, 0, 'h0F, 0, 0);
    checkOutput("abort_load", 'h0F, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 'h00, 1, 4);
    checkOutput("abort_accept", 'h0F, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 'h00, 0, 0);
    checkOutput("abort_run1", 'h07, 1, 1, 0);
    applyStimulus(0, 1, 0, 0, 'h00, 1, 4);
    checkOutput("abort_reset", 'h00, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 0, 0, 'h00, 0, 0);
      checkOutput($sformatf("abort_quiet%0d", i), 'h00, 0, 0, 0);
    end

    // Back-to-back: start held high; DONE ignores it, the following IDLE
    // cycle accepts the next burst.
    $display("[TB] Back-to-back sequence");
    applyStimulus(1, 3, 0, 0, 'h01, 0, 0);
    checkOutput("b2b_load", 'h01, 0, 0, 0);
    applyStimulus(1, 2, 0, 1, 'h00, 1, 1);
    checkOutput("b2b_accept1", 'h01, 0, 1, 0);
    applyStimulus(1, 2, 0, 1, 'h00, 1, 1);
    checkOutput("b2b_done1", 'h03, 0, 0, 1);
    applyStimulus(1, 2, 0, 1, 'h00, 1, 1);
    checkOutput("b2b_gap", 'h03, 0, 0, 0);
    applyStimulus(1, 2, 0, 1, 'h00, 1, 1);
    checkOutput("b2b_accept2", 'h03, 0, 1, 0);
    applyStimulus(1, 0, 0, 1, 'h00, 0, 0);
    checkOutput("b2b_done2", 'h07, 0, 0, 1);

    // Randomized run against the model; reset is rare, start fairly common.
    $display("[TB] Random phase");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(39) != 0), int'($urandom_range(7)),
                    1'($urandom_range(1)), 1'($urandom_range(1)),
                    int'($urandom_range(255)), ($urandom_range(3) == 0),
                    int'($urandom_range(15)));
      checkModel($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
